// File: rtl/spi_pkg.sv
// ============================================================================
//  Module      : spi_pkg
//  Description : Shared types and constants for the SPI MISO slave interface.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package spi_pkg;

    localparam int SPI_DEFAULT_WIDTH = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DRAIN = 2'd2
    } spi_miso_state_t;

endpackage

`default_nettype wire

// File: rtl/spi_miso_interface_if.sv
// ============================================================================
//  Module      : spi_miso_interface_if
//  Description : Transmit-load handshake and frame status bundle.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface spi_miso_interface_if
    import spi_pkg::*;
#(
    parameter int WIDTH = SPI_DEFAULT_WIDTH
) ();

    logic [WIDTH-1:0] tx_data;
    logic             tx_valid;
    logic             tx_ready;
    logic             frame_done;
    logic             frame_abort;
    logic             underrun;

    modport master (
        output tx_data, tx_valid,
        input  tx_ready, frame_done, frame_abort, underrun
    );

    modport slave (
        input  tx_data, tx_valid,
        output tx_ready, frame_done, frame_abort, underrun
    );

endinterface

`default_nettype wire

// File: rtl/sync_edge_detect.sv
// ============================================================================
//  Module      : sync_edge_detect
//  Description : Multi-flop synchronizer with single-cycle rise/fall pulses.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sync_edge_detect #(
    parameter int   STAGES     = 2,
    parameter logic IDLE_LEVEL = 1'b0
) (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic i_async,
    output logic      o_rise,
    output logic      o_fall
);

    logic [STAGES-1:0] r_sync;
    logic              r_prev;
    logic              w_sync;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync <= {STAGES{IDLE_LEVEL}};
            r_prev <= IDLE_LEVEL;
        end else begin
            r_sync <= {r_sync[STAGES-2:0], i_async};
            r_prev <= r_sync[STAGES-1];
        end
    end

    assign w_sync = r_sync[STAGES-1];
    assign o_rise = w_sync & ~r_prev;
    assign o_fall = ~w_sync & r_prev;

endmodule

`default_nettype wire

// File: rtl/spi_miso_interface.sv
// ============================================================================
//  Module      : spi_miso_interface
//  Description : SPI mode-0 slave transmitter with holding register.
//                Optional macro SPI_MISO_REPEAT_EN repeats the last word on
//                underrun instead of sending zeros.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module spi_miso_interface
    import spi_pkg::*;
#(
    parameter int WIDTH       = SPI_DEFAULT_WIDTH,
    parameter int SYNC_STAGES = 2
) (
    input  wire logic            sys_clk,
    input  wire logic            sys_reset,
    input  wire logic            spi_clk,
    input  wire logic            spi_cs_n,
    output logic                 spi_miso,
    output logic                 spi_miso_oe,
    spi_miso_interface_if.slave  bus
);

    localparam int                 c_cnt_w = $clog2(WIDTH + 1);
    localparam logic [c_cnt_w-1:0] c_last  = c_cnt_w'(WIDTH - 1);

    spi_miso_state_t    r_state, w_state_next;
    logic [WIDTH-1:0]   r_hold, r_shift, w_shift_next, w_load_word, w_underrun_word;
    logic               r_hold_full;
    logic [c_cnt_w-1:0] r_cnt, w_cnt_next;
    logic               w_start, w_done, w_abort, w_tx_fire;
    logic               r_done, r_abort, r_underrun, r_miso, r_oe;
    logic               w_sclk_rise, w_sclk_fall, w_cs_rise, w_cs_fall;

    sync_edge_detect #(.STAGES(SYNC_STAGES), .IDLE_LEVEL(1'b0)) u_sync_sclk (
        .clk     (sys_clk),
        .rst     (sys_reset),
        .i_async (spi_clk),
        .o_rise  (w_sclk_rise),
        .o_fall  (w_sclk_fall)
    );

    sync_edge_detect #(.STAGES(SYNC_STAGES), .IDLE_LEVEL(1'b1)) u_sync_cs (
        .clk     (sys_clk),
        .rst     (sys_reset),
        .i_async (spi_cs_n),
        .o_rise  (w_cs_rise),
        .o_fall  (w_cs_fall)
    );

`ifdef SPI_MISO_REPEAT_EN
    logic [WIDTH-1:0] r_last_word;

    always_ff @(posedge sys_clk) begin
        if (sys_reset) begin
            r_last_word <= '0;
        end else if (w_start) begin
            r_last_word <= w_load_word;
        end
    end

    assign w_underrun_word = r_last_word;
`else
    assign w_underrun_word = '0;
`endif

    assign w_tx_fire   = bus.tx_valid && !r_hold_full;
    assign w_load_word = r_hold_full ? r_hold : w_underrun_word;

    always_ff @(posedge sys_clk) begin
        if (sys_reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_shift_next = r_shift;
        w_cnt_next   = r_cnt;
        w_start      = 1'b0;
        w_done       = 1'b0;
        w_abort      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_cs_fall) begin
                    w_start      = 1'b1;
                    w_state_next = ST_SHIFT;
                    w_shift_next = w_load_word;
                    w_cnt_next   = '0;
                end
            end
            ST_SHIFT: begin
                // CS release wins over any clock edge seen in the same cycle
                if (w_cs_rise) begin
                    w_abort      = 1'b1;
                    w_state_next = ST_IDLE;
                end else if (w_sclk_rise) begin
                    w_cnt_next = r_cnt + 1'b1;
                    if (r_cnt == c_last) begin
                        w_done       = 1'b1;
                        w_state_next = ST_DRAIN;
                    end
                end else if (w_sclk_fall) begin
                    w_shift_next = {r_shift[WIDTH-2:0], 1'b0};
                end
            end
            ST_DRAIN: begin
                if (w_cs_rise) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (sys_reset) begin
            r_hold      <= '0;
            r_hold_full <= 1'b0;
            r_shift     <= '0;
            r_cnt       <= '0;
            r_done      <= 1'b0;
            r_abort     <= 1'b0;
            r_underrun  <= 1'b0;
            r_miso      <= 1'b0;
            r_oe        <= 1'b0;
        end else begin
            // A word accepted during frame start is kept for the following frame
            if (w_tx_fire) begin
                r_hold      <= bus.tx_data;
                r_hold_full <= 1'b1;
            end else if (w_start) begin
                r_hold_full <= 1'b0;
            end
            r_shift    <= w_shift_next;
            r_cnt      <= w_cnt_next;
            r_done     <= w_done;
            r_abort    <= w_abort;
            r_underrun <= w_start && !r_hold_full;
            r_miso     <= (w_state_next == ST_SHIFT) && w_shift_next[WIDTH-1];
            r_oe       <= (w_state_next != ST_IDLE);
        end
    end

    assign spi_miso        = r_miso;
    assign spi_miso_oe     = r_oe;
    assign bus.tx_ready    = !r_hold_full;
    assign bus.frame_done  = r_done;
    assign bus.frame_abort = r_abort;
    assign bus.underrun    = r_underrun;

endmodule

`default_nettype wire

// File: tb/tb_spi_miso_interface.sv
// ============================================================================
//  Module      : tb_spi_miso_interface
//  Description : Directed bench: a mode-0 host model reads frames back.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_spi_miso_interface;

    logic sys_clk   = 1'b0;
    logic sys_reset = 1'b1;
    logic spi_clk   = 1'b0;
    logic spi_cs_n  = 1'b1;
    logic spi_miso;
    logic spi_miso_oe;

    spi_miso_interface_if #(.WIDTH(16)) bus ();

    spi_miso_interface #(.WIDTH(16), .SYNC_STAGES(2)) dut (
        .sys_clk     (sys_clk),
        .sys_reset   (sys_reset),
        .spi_clk     (spi_clk),
        .spi_cs_n    (spi_cs_n),
        .spi_miso    (spi_miso),
        .spi_miso_oe (spi_miso_oe),
        .bus         (bus)
    );

    always #5 sys_clk = ~sys_clk;

    int n_checks = 0;
    int n_fail   = 0;
    int n_done   = 0;
    int n_abort  = 0;
    int n_under  = 0;

    always @(posedge sys_clk) begin
        if (bus.frame_done)  n_done  <= n_done + 1;
        if (bus.frame_abort) n_abort <= n_abort + 1;
        if (bus.underrun)    n_under <= n_under + 1;
    end

    typedef struct {
        string       name;
        bit          load;
        logic [15:0] word;
        int          nbits;
        logic [31:0] exp_rx;
        int          exp_done;
        int          exp_abort;
        int          exp_under;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic load_word(input logic [15:0] w, input string nm);
        bit got = 0;
        @(negedge sys_clk);
        bus.tx_data  = w;
        bus.tx_valid = 1'b1;
        for (int k = 0; k < 40 && !got; k++) begin
            if (bus.tx_ready) got = 1;
            else @(negedge sys_clk);
        end
        @(negedge sys_clk);
        bus.tx_valid = 1'b0;
        check({nm, "_load_accepted"}, 32'(got), 32'd1);
        check({nm, "_ready_low_after_load"}, 32'(bus.tx_ready), 32'd0);
    endtask

    // One SCLK period (10 sys_clk); host samples MISO on the rising edge
    task automatic sclk_bit(output logic b);
        @(negedge sys_clk);
        spi_clk = 1'b1;
        b = spi_miso;
        repeat (5) @(negedge sys_clk);
        spi_clk = 1'b0;
        repeat (4) @(negedge sys_clk);
    endtask

    task automatic spi_frame(input int nbits, output logic [31:0] rx, output logic rdy);
        logic b;
        rx  = '0;
        rdy = 1'b0;
        @(negedge sys_clk);
        spi_cs_n = 1'b0;
        repeat (6) @(negedge sys_clk);
        for (int i = 0; i < nbits; i++) begin
            sclk_bit(b);
            rx = {rx[30:0], b};
            if (i == 0) rdy = bus.tx_ready;
        end
        repeat (5) @(negedge sys_clk);
        spi_cs_n = 1'b1;
        repeat (8) @(negedge sys_clk);
    endtask

    initial begin
        #500us;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] rx;
        logic        rdy, dummy;
        int          d0, a0, u0;
        bit          got;

        bus.tx_data  = '0;
        bus.tx_valid = 1'b0;

        vecs[0] = '{"a5c3",     1'b1, 16'hA5C3, 16, 32'h0000A5C3, 1, 0, 0};
        vecs[1] = '{"w1234",    1'b1, 16'h1234, 16, 32'h00001234, 1, 0, 0};
`ifdef SPI_MISO_REPEAT_EN
        vecs[2] = '{"underrun", 1'b0, 16'h0000, 16, 32'h00001234, 1, 0, 1};
`else
        vecs[2] = '{"underrun", 1'b0, 16'h0000, 16, 32'h00000000, 1, 0, 1};
`endif
        vecs[3] = '{"abort7",   1'b1, 16'hFFFF,  7, 32'h0000007F, 0, 1, 0};
        vecs[4] = '{"w0f0f",    1'b1, 16'h0F0F, 16, 32'h00000F0F, 1, 0, 0};
        vecs[5] = '{"sclk20",   1'b1, 16'h8001, 20, 32'h00080010, 1, 0, 0};

        repeat (4) @(negedge sys_clk);
        check("rst_tx_ready", 32'(bus.tx_ready),    32'd1);
        check("rst_miso",     32'(spi_miso),        32'd0);
        check("rst_oe",       32'(spi_miso_oe),     32'd0);
        check("rst_pulses",   {29'd0, bus.frame_done, bus.frame_abort, bus.underrun}, 32'd0);
        sys_reset = 1'b0;
        repeat (4) @(negedge sys_clk);

        foreach (vecs[i]) begin
            if (vecs[i].load) load_word(vecs[i].word, vecs[i].name);
            d0 = n_done; a0 = n_abort; u0 = n_under;
            spi_frame(vecs[i].nbits, rx, rdy);
            check({vecs[i].name, "_rx"},    rx, vecs[i].exp_rx);
            check({vecs[i].name, "_done"},  32'(n_done - d0),  32'(vecs[i].exp_done));
            check({vecs[i].name, "_abort"}, 32'(n_abort - a0), 32'(vecs[i].exp_abort));
            check({vecs[i].name, "_under"}, 32'(n_under - u0), 32'(vecs[i].exp_under));
            check({vecs[i].name, "_ready_in_frame"}, 32'(rdy), 32'd1);
            check({vecs[i].name, "_oe_idle"}, 32'(spi_miso_oe), 32'd0);
        end

        // New word offered exactly in the CS-fall detect cycle while holding is full
        load_word(16'h3333, "w3333");
        u0 = n_under;
        got = 0;
        fork
            spi_frame(16, rx, rdy);
            begin
                @(negedge sys_clk);
                repeat (2) @(posedge sys_clk);
                @(negedge sys_clk);
                bus.tx_data  = 16'h5555;
                bus.tx_valid = 1'b1;
                for (int k = 0; k < 40 && !got; k++) begin
                    if (bus.tx_ready) got = 1;
                    else @(negedge sys_clk);
                end
                @(negedge sys_clk);
                bus.tx_valid = 1'b0;
            end
        join
        check("race_accepted",   32'(got), 32'd1);
        check("race_cur_frame",  rx, 32'h00003333);
        spi_frame(16, rx, rdy);
        check("race_next_frame", rx, 32'h00005555);
        check("race_no_underrun", 32'(n_under - u0), 32'd0);

        // Reset in the middle of a frame
        load_word(16'hBEEF, "wbeef");
        a0 = n_abort;
        @(negedge sys_clk);
        spi_cs_n = 1'b0;
        repeat (6) @(negedge sys_clk);
        for (int i = 0; i < 5; i++) sclk_bit(dummy);
        check("midrst_oe_before", 32'(spi_miso_oe), 32'd1);
        sys_reset = 1'b1;
        @(negedge sys_clk);
        spi_cs_n = 1'b1;
        repeat (3) @(negedge sys_clk);
        check("midrst_miso",  32'(spi_miso),     32'd0);
        check("midrst_oe",    32'(spi_miso_oe),  32'd0);
        check("midrst_ready", 32'(bus.tx_ready), 32'd1);
        sys_reset = 1'b0;
        repeat (8) @(negedge sys_clk);
        check("postrst_oe",    32'(spi_miso_oe),  32'd0);
        check("postrst_ready", 32'(bus.tx_ready), 32'd1);
        check("postrst_abort", 32'(n_abort - a0), 32'd0);

        load_word(16'hCAFE, "wcafe");
        spi_frame(16, rx, rdy);
        check("postrst_frame", rx, 32'h0000CAFE);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/spi_miso_interface.md
SPI_MISO_INTERFACE -- requirements
Module: spi_miso_interface

Interface
- REQ-001: Parameter WIDTH, default 16; frame length in bits, range 2..32.
- REQ-002: Parameter SYNC_STAGES, default 2; synchronizer depth for spi_clk and spi_cs_n, range 2..3.
- REQ-003: sys_clk, input, 1; single system clock, all logic on its rising edge.
- REQ-004: sys_reset, input, 1; synchronous, active-high reset.
- REQ-005: spi_clk, input, 1; host SCLK, mode 0 (CPOL=0, CPHA=0), asynchronous to sys_clk.
- REQ-006: spi_cs_n, input, 1; host chip select, active-low, asynchronous.
- REQ-007: spi_miso, output, 1; serial data to host, MSB first.
- REQ-008: spi_miso_oe, output, 1; high while the frame is selected, for the pad tristate.
- REQ-009: tx_data, input, WIDTH; next word to transmit.
- REQ-010: tx_valid, input, 1 / tx_ready, output, 1; load handshake, transfer on tx_valid && tx_ready.
- REQ-011: frame_done, output, 1; one-cycle pulse after WIDTH bits have been shifted.
- REQ-012: frame_abort, output, 1; one-cycle pulse when CS deasserts before WIDTH bits.
- REQ-013: underrun, output, 1; one-cycle pulse when a frame starts with the holding register empty.

Function
- REQ-014: spi_clk and spi_cs_n SHALL be synchronized through SYNC_STAGES flops, then edge-detected in sys_clk; sys_clk >= 8x spi_clk frequency is required.
- REQ-015: A WIDTH-bit holding register SHALL be written on a tx handshake; tx_ready = holding register empty.
- REQ-016: States: IDLE, SHIFT, DRAIN.
- REQ-017: IDLE -> SHIFT on synced CS falling edge; the shift register SHALL load from the holding register in that cycle, and the holding register SHALL empty, so tx_ready rises the next cycle.
- REQ-018: If the holding register is empty at frame start, the shift register SHALL load the underrun word (see Configuration) and pulse underrun.
- REQ-019: A tx handshake in the same cycle as frame start SHALL NOT feed that frame; the word SHALL be held for the next frame.
- REQ-020: spi_miso SHALL equal shift register MSB, registered, valid no later than SYNC_STAGES+2 sys_clk cycles after the CS falling edge.
- REQ-021: In SHIFT, on each synced SCLK rising edge the bit counter SHALL increment; on each synced SCLK falling edge the shift register SHALL shift left, filling with 0.
- REQ-022: After the WIDTH-th rising edge: pulse frame_done, go to DRAIN; in DRAIN, spi_miso SHALL be 0 regardless of further SCLK edges.
- REQ-023: Synced CS rising edge in SHIFT SHALL pulse frame_abort and go to IDLE; in DRAIN, it SHALL go to IDLE without a pulse.
- REQ-024: spi_miso_oe = 1 in SHIFT and DRAIN, else 0; spi_miso = 0 whenever spi_miso_oe = 0.
- REQ-025: The aborted word SHALL be discarded, not re-queued.

Reset
- REQ-026: Reset SHALL force: state IDLE, holding register empty, tx_ready 1, spi_miso 0, spi_miso_oe 0, frame_done/frame_abort/underrun 0, counter 0, synchronizers to idle levels (spi_clk 0, spi_cs_n 1).
- REQ-027: Reset mid-frame SHALL return to IDLE without frame_abort; a frame is not started until a fresh CS falling edge is detected after reset.

Configuration
- REQ-028: Macro SPI_MISO_REPEAT_EN: when defined, the underrun word SHALL be the last word loaded into the shift register (0 if none since reset); when undefined, the underrun word SHALL be all zeros. underrun pulses in both builds.

Structure
- REQ-029: Package spi_pkg SHALL hold the state enum spi_miso_state_t and constant SPI_DEFAULT_WIDTH = 16.
- REQ-030: Sub-module sync_edge_detect (synchronizer plus rise/fall pulses) SHALL be instantiated once for spi_clk and once for spi_cs_n.

Verification
- REQ-031: Load 16'hA5C3, then run one 16-bit mode-0 frame at sys_clk/10 -> host samples 16'hA5C3, one frame_done, tx_ready high from frame start.
- REQ-032: Frame with no load -> host samples 16'h0000 and underrun pulses once; with SPI_MISO_REPEAT_EN after a 16'h1234 frame, host samples 16'h1234.
- REQ-033: Load 16'hFFFF, deassert CS after 7 bits -> frame_abort once, no frame_done; next frame with load 16'h0F0F returns 16'h0F0F.
- REQ-034: 20 SCLKs in a frame loaded with 16'h8001 -> first 16 bits 16'h8001, bits 17-20 zero, single frame_done.
- REQ-035: tx_valid asserted in the exact CS-falling detect cycle with 16'h5555 while holding holds 16'h3333 -> current frame 16'h3333, next frame 16'h5555.
- REQ-036: Assert sys_reset after bit 5 -> outputs at reset values, no frame_abort, tx_ready 1.
